// File: rtl/loader_pkg.sv
// Shared definitions for the IMEM boot loader: FSM state encoding and
// image-format constants.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR0    = 3'd1,
      ST_HDR1    = 3'd2,
      ST_DATA    = 3'd3,
      ST_RELEASE = 3'd4,
      ST_RUN     = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_W          = 8 * HDR_BYTES;

   // States in which the stream is being consumed or the core is settling.
   function automatic logic is_busy(input state_t s);
      return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_RELEASE);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted stream bytes into a 32-bit little-endian word; flags the
// cycle in which the last byte of a word arrives.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      data_q, data_d;

   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      idx_d      = idx_q;
      data_d     = data_q;
      word_valid = 1'b0;
      if (clear) begin
         idx_d  = '0;
         data_d = '0;
      end else if (byte_en) begin
         data_d[{idx_q, 3'b000} +: 8] = byte_in;
         idx_d      = idx_q + IDX_W'(1);
         word_valid = (idx_q == LAST_IDX);
      end
   end

   // The merged value is presented in the same cycle as the last byte so the
   // top can register it alongside the write strobe.
   assign word = data_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot sequencer: holds the core in reset, loads a length-prefixed byte
// image into IMEM word by word, then releases the core after a fixed delay.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int RELEASE_DLY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int WL_W  = ADDR_W + 1;
   localparam int EXT_W = HDR_W + 1;
   localparam int CNT_W = $clog2(RELEASE_DLY + 1);
   localparam logic [EXT_W-1:0] CAPACITY = EXT_W'(1) << ADDR_W;

   state_t             state_q, state_d;
   logic [7:0]         hdr_lo_q, hdr_lo_d;
   logic [HDR_W-1:0]   num_words_q, num_words_d;
   logic [WL_W-1:0]    words_loaded_q, words_loaded_d;
   logic [CNT_W-1:0]   rel_cnt_q, rel_cnt_d;
   logic               imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
   logic [31:0]        imem_wdata_q, imem_wdata_d;
   logic               core_rst_q, core_rst_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               accept;
   logic [HDR_W-1:0]   hdr_n;
   logic               pk_clear;
   logic               pk_en;
   logic               pk_word_valid;
   logic [31:0]        pk_word;

   assign s_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
   assign accept  = s_valid && s_ready;
   assign hdr_n   = {s_data, hdr_lo_q};

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pk_clear),
      .byte_en    (pk_en),
      .byte_in    (s_data),
      .word_valid (pk_word_valid),
      .word       (pk_word)
   );

   // NOTE: combinational logic uses blocking assignments so later statements
   // see the values computed earlier in the same block.
   always_comb begin
      state_d        = state_q;
      hdr_lo_d       = hdr_lo_q;
      num_words_d    = num_words_q;
      words_loaded_d = words_loaded_q;
      rel_cnt_d      = rel_cnt_q;
      imem_we_d      = 1'b0;
      imem_addr_d    = imem_addr_q;
      imem_wdata_d   = imem_wdata_q;
      pk_clear       = 1'b0;
      pk_en          = 1'b0;

      case (state_q)
         ST_IDLE, ST_RUN, ST_ERROR: begin
            if (start) state_d = ST_HDR0;
         end
         ST_HDR0: begin
            if (accept) begin
               hdr_lo_d = s_data;
               state_d  = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (accept) begin
               num_words_d = hdr_n;
               if (hdr_n == '0) begin
                  state_d   = ST_RELEASE;
                  rel_cnt_d = CNT_W'(RELEASE_DLY);
               end else if (EXT_W'(hdr_n) > CAPACITY) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d        = ST_DATA;
                  words_loaded_d = '0;
                  pk_clear       = 1'b1;
               end
            end
         end
         ST_DATA: begin
            pk_en = accept;
            if (pk_word_valid) begin
               imem_we_d      = 1'b1;
               imem_addr_d    = words_loaded_q[ADDR_W-1:0];
               imem_wdata_d   = pk_word;
               words_loaded_d = words_loaded_q + WL_W'(1);
               if ((EXT_W'(words_loaded_q) + EXT_W'(1)) == EXT_W'(num_words_q)) begin
                  state_d   = ST_RELEASE;
                  rel_cnt_d = CNT_W'(RELEASE_DLY);
               end
            end
         end
         ST_RELEASE: begin
            // The count is loaded on entry, so the last step lands exactly
            // RELEASE_DLY edges after the final byte.
            if (rel_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
            else                        rel_cnt_d = rel_cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Status flags follow the next state so they change on the same edge.
      core_rst_d = (state_d != ST_RUN);
      busy_d     = is_busy(state_d);
      done_d     = (state_d == ST_RUN);
      err_d      = (state_d == ST_ERROR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         hdr_lo_q       <= '0;
         num_words_q    <= '0;
         words_loaded_q <= '0;
         rel_cnt_q      <= '0;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= '0;
         core_rst_q     <= 1'b1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         hdr_lo_q       <= hdr_lo_d;
         num_words_q    <= num_words_d;
         words_loaded_q <= words_loaded_d;
         rel_cnt_q      <= rel_cnt_d;
         imem_we_q      <= imem_we_d;
         imem_addr_q    <= imem_addr_d;
         imem_wdata_q   <= imem_wdata_d;
         core_rst_q     <= core_rst_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign core_rst     = core_rst_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, stalled, empty, oversize,
// capacity-boundary, restart and mid-load reset images.
module tb_imem_loader;

   localparam int ADDR_W      = 4;
   localparam int RELEASE_DLY = 4;
   localparam int DEPTH       = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic [7:0]        s_data = 8'h00;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.ADDR_W(ADDR_W), .RELEASE_DLY(RELEASE_DLY)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference IMEM, filled from the observed write strobes.
   logic [31:0] mem_model [DEPTH];
   int          we_cnt = 0;

   always @(negedge clk) begin
      if (imem_we) begin
         mem_model[imem_addr] = imem_wdata;
         we_cnt++;
      end
   end

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      logic [31:0] exp_word;
      int          gap_pre;
      int          gap_mid;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      @(negedge clk);
      repeat (gap) @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      t = 0;
      while (!s_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
         s_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         s_valid = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called 1ns after the final byte edge T; core_rst must fall at T+RELEASE_DLY.
   task automatic check_release();
      check("rel_core_rst_T", {31'd0, core_rst}, 32'd1);
      check("rel_busy_T", {31'd0, busy}, 32'd1);
      for (int k = 1; k < RELEASE_DLY; k++) begin
         @(posedge clk);
         #1;
         check("rel_core_rst_hold", {31'd0, core_rst}, 32'd1);
         check("rel_we_low", {31'd0, imem_we}, 32'd0);
      end
      @(posedge clk);
      #1;
      check("rel_core_rst_fall", {31'd0, core_rst}, 32'd0);
      check("rel_done", {31'd0, done}, 32'd1);
      check("rel_busy_low", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_vals();
      check("rv_core_rst", {31'd0, core_rst}, 32'd1);
      check("rv_s_ready", {31'd0, s_ready}, 32'd0);
      check("rv_imem_we", {31'd0, imem_we}, 32'd0);
      check("rv_imem_addr", 32'(imem_addr), 32'd0);
      check("rv_imem_wdata", imem_wdata, 32'd0);
      check("rv_busy", {31'd0, busy}, 32'd0);
      check("rv_done", {31'd0, done}, 32'd0);
      check("rv_err", {31'd0, err}, 32'd0);
      check("rv_words_loaded", 32'(words_loaded), 32'd0);
   endtask

   task automatic check_write(input string name, input int addr, input logic [31:0] data);
      check({name, "_we"}, {31'd0, imem_we}, 32'd1);
      check({name, "_addr"}, 32'(imem_addr), 32'(addr));
      check({name, "_wdata"}, imem_wdata, data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int we_base;
      logic [7:0] bi;

      foreach (mem_model[i]) mem_model[i] = 32'h0;

      vecs[0] = '{8'h13, 8'h00, 8'h50, 8'h00, 32'h00500013, 0, 0};
      vecs[1] = '{8'hB3, 8'h00, 8'hA0, 8'h00, 32'h00A000B3, 2, 5};
      vecs[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF, 3, 1};
      vecs[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 0, 5};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_core_rst", {31'd0, core_rst}, 32'd1);

      // Nominal two-word image.
      pulse_start();
      check("nom_start_busy", {31'd0, busy}, 32'd1);
      check("nom_start_ready", {31'd0, s_ready}, 32'd1);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h50, 0);
      send_byte(8'h00, 0);
      check_write("nom_w0", 0, 32'h00500013);
      send_byte(8'hB3, 0);
      check("nom_we_gap", {31'd0, imem_we}, 32'd0);
      send_byte(8'h00, 0);
      send_byte(8'hA0, 0);
      send_byte(8'h00, 0);
      check_write("nom_w1", 1, 32'h00A000B3);
      check("nom_words_loaded", 32'(words_loaded), 32'd2);
      check_release();
      check("nom_we_count", 32'(we_cnt), 32'd2);
      check("nom_mem0", mem_model[0], 32'h00500013);
      check("nom_mem1", mem_model[1], 32'h00A000B3);

      // Reload from RUN with stalls and a start pulse ignored mid-word.
      we_base = we_cnt;
      pulse_start();
      check("reload_core_rst", {31'd0, core_rst}, 32'd1);
      check("reload_ready", {31'd0, s_ready}, 32'd1);
      check("reload_done", {31'd0, done}, 32'd0);
      send_byte(8'h04, 1);
      send_byte(8'h00, 2);
      for (int i = 0; i < 4; i++) begin
         send_byte(vecs[i].b0, vecs[i].gap_pre);
         send_byte(vecs[i].b1, vecs[i].gap_mid);
         if (i == 2) begin
            pulse_start();
            check("mid_start_busy", {31'd0, busy}, 32'd1);
            check("mid_start_ready", {31'd0, s_ready}, 32'd1);
         end
         send_byte(vecs[i].b2, 1);
         send_byte(vecs[i].b3, vecs[i].gap_mid);
         check_write("tbl_w", i, vecs[i].exp_word);
      end
      check_release();
      for (int i = 0; i < 4; i++) check("tbl_mem", mem_model[i], vecs[i].exp_word);
      check("tbl_we_count", 32'(we_cnt - we_base), 32'd4);
      check("tbl_words_loaded", 32'(words_loaded), 32'd4);

      // Empty image: straight to RELEASE, no writes, count retained.
      we_base = we_cnt;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("n0_ready", {31'd0, s_ready}, 32'd0);
      check("n0_we", {31'd0, imem_we}, 32'd0);
      check_release();
      check("n0_we_count", 32'(we_cnt - we_base), 32'd0);
      check("n0_words_loaded", 32'(words_loaded), 32'd4);

      // Oversize header, then recovery with a valid image.
      pulse_start();
      send_byte(8'h11, 0);
      send_byte(8'h00, 0);
      check("n17_err", {31'd0, err}, 32'd1);
      check("n17_ready", {31'd0, s_ready}, 32'd0);
      check("n17_core_rst", {31'd0, core_rst}, 32'd1);
      check("n17_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("n17_err_hold", {31'd0, err}, 32'd1);
      pulse_start();
      check("n17_err_clear", {31'd0, err}, 32'd0);
      check("n17_restart_ready", {31'd0, s_ready}, 32'd1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      check_write("rec_w0", 0, 32'h12345678);
      check("rec_words_loaded", 32'(words_loaded), 32'd1);
      check_release();

      // Capacity boundary: exactly 2^ADDR_W words.
      pulse_start();
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < DEPTH; i++) begin
         bi = 8'(i);
         send_byte(bi, 0);
         send_byte(bi + 8'h10, 0);
         send_byte(bi + 8'h20, 0);
         send_byte(bi + 8'h30, 0);
      end
      check_write("cap_last", DEPTH - 1, 32'h3F2F1F0F);
      check("cap_words_loaded", 32'(words_loaded), 32'd16);
      check_release();
      for (int i = 0; i < DEPTH; i++) begin
         bi = 8'(i);
         check("cap_mem", mem_model[i], {bi + 8'h30, bi + 8'h20, bi + 8'h10, bi});
      end

      // Reset in the middle of DATA, then a fresh one-word load.
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hDE, 0);
      check_write("post_rst_w0", 0, 32'hDEADBEEF);
      check_release();
      check("post_rst_mem0", mem_model[0], 32'hDEADBEEF);
      check("post_rst_words_loaded", 32'(words_loaded), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot sequencer for the single-cycle RISC-V core. While it holds the core in reset, it receives a program image as a byte stream over a valid/ready handshake and packs the bytes into 32-bit little-endian words. It writes each word to the instruction-memory write port, then releases the core after a fixed settling delay. Sits between the board-level host link and the core top: drives the core's reset and the IMEM write port.

## Interface
- ADDR_W, 10, IMEM word-address width; capacity 2^ADDR_W words
- RELEASE_DLY, 4, cycles between the last IMEM write and core reset deassertion (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, RUN, ERROR
- s_valid  in  1  byte available
- s_data  in  8  stream byte
- s_ready  out  1  loader accepts byte this cycle
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_addr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  IMEM write data
- core_rst  out  1  active-high reset to core (PC, register file)
- busy  out  1  high in HDR0, HDR1, DATA, RELEASE
- done  out  1  high in RUN
- err  out  1  high in ERROR
- words_loaded  out  ADDR_W+1  words written in current/last load

## Operation
- Reset values: state IDLE, core_rst=1, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, words_loaded=0.
- Image format: 2-byte little-endian word count N, then 4N bytes; each word is sent LSB first.
- States:
  - IDLE: core_rst=1; start → HDR0.
  - HDR0: accept low byte of N → HDR1.
  - HDR1: accept high byte. If N=0 → RELEASE. If N>2^ADDR_W → ERROR. Otherwise → DATA, with words_loaded=0 and byte index=0.
  - DATA: accept bytes. The 4th byte of a word issues an IMEM write at addr=words_loaded, then words_loaded increments. After word N → RELEASE.
  - RELEASE: down-counter loaded with RELEASE_DLY; reaching 0 → RUN.
  - RUN: core_rst=0, done=1. start → HDR0 with core_rst reasserted on the same edge (reload).
  - ERROR: core_rst=1, err=1. start → HDR0 with err cleared.
- start is ignored in HDR0, HDR1, DATA and RELEASE. An in-progress load is never restarted.
- s_ready=1 exactly in HDR0, HDR1 and DATA. It is a function of state only and never depends on s_valid. A byte is consumed on a rising edge where s_valid and s_ready are both 1. s_data is don't-care otherwise.
- Word packing: byte k of a word goes to imem_wdata[8k+7:8k]. Stalls on s_valid may occur between any two bytes without corrupting the partial word.
- words_loaded holds its final value until the next HDR1→DATA transition.
- Capacity boundary: N=2^ADDR_W is legal. The last write goes to addr 2^ADDR_W−1 and words_loaded reaches 2^ADDR_W (hence width ADDR_W+1).
- Reset mid-load: all state is discarded immediately and core_rst=1. IMEM contents already written are not cleared.

## Timing
- All outputs are registered except s_ready, which is decoded from the state register.
- Write latency: the 4th byte of a word is accepted at edge T. imem_we, imem_addr and imem_wdata are valid for exactly the cycle between T and T+1. Back-to-back words produce no more than one strobe per 4 accepted bytes.
- Release latency: the last byte is accepted at edge T, entering RELEASE. core_rst falls and done rises at edge T+RELEASE_DLY.
- For N=0, core_rst falls at edge (HDR1 accept)+RELEASE_DLY, and imem_we never pulses.
- From RUN, start at edge T gives core_rst=1 and s_ready=1 from edge T.
- Header error: the high byte is accepted at edge T. err=1 and s_ready=0 from edge T.

## Structure
- Shared package loader_pkg:
  - state encoding localparams (IDLE, HDR0, HDR1, DATA, RELEASE, RUN, ERROR; 3-bit)
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
- One sub-module: byte_packer. It holds the 2-bit byte index and the 32-bit shift/merge register, and produces word_valid on the 4th accepted byte. Its clear input is driven by the top FSM on HDR1→DATA.
- The top module holds the FSM, the header register, words_loaded, the release counter, and the output registers.

## Test plan
- Nominal, ADDR_W=4, RELEASE_DLY=4: start, stream 02 00 13 00 50 00 B3 00 A0 00 → writes 0x00500013@0 and 0x00A000B3@1; core_rst falls 4 cycles after the last byte; done=1; words_loaded=2.
- Random s_valid gaps (including 5-cycle stalls mid-word) on the same image → identical writes and data; imem_we pulses exactly twice.
- N=0 (00 00) → no imem_we; RELEASE then RUN after 4 cycles. N=17 with ADDR_W=4 → err=1, s_ready=0, core_rst=1; start then a valid image → err clears and the load succeeds.
- N=16 with ADDR_W=4 → last write at addr 15; words_loaded=16; RUN reached.
- start pulsed mid-DATA → ignored, load completes unchanged. start in RUN → core_rst=1 on the same edge and reload proceeds.
- rst asserted during DATA after 5 bytes → all outputs at reset values immediately. Post-reset load of one word 0xDEADBEEF (EF BE AD DE) → write at addr 0.
